// File: rtl/kf_arith_pkg.sv
// Shared sign-magnitude arithmetic helpers for the Kalman-filter datapath.
// Operands are KF_W-bit sign-magnitude values; intermediates are KF_W+1-bit two's complement.
package kf_arith_pkg;

    localparam int KF_W = 24;
    localparam logic [KF_W-2:0] MAG_MAX = {(KF_W-1){1'b1}};

    typedef logic [KF_W-1:0]        sm_t;
    typedef logic signed [KF_W:0]   tc_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Negative zero maps to zero because only the magnitude is negated.
    function automatic tc_t sm_to_tc(input sm_t v);
        tc_t mag;
        mag = {2'b00, v[KF_W-2:0]};
        if (v[KF_W-1]) begin
            sm_to_tc = -mag;
        end else begin
            sm_to_tc = mag;
        end
    endfunction

    function automatic sm_t tc_to_sm_sat(input tc_t z);
        logic            neg;
        logic [KF_W:0]   mag;
        logic [KF_W-2:0] m;
        neg = z[KF_W];
        if (neg) begin
            mag = -z;
        end else begin
            mag = z;
        end
        if (mag > {2'b00, MAG_MAX}) begin
            m = MAG_MAX;
        end else begin
            m = mag[KF_W-2:0];
        end
        tc_to_sm_sat = {neg, m};
    endfunction

endpackage

// File: rtl/adder_subs.sv
// Combinational sign-magnitude saturating adder/subtractor (z = x + y or x - y).
module adder_subs
    import kf_arith_pkg::*;
(
    input  logic [KF_W-1:0] x,
    input  logic [KF_W-1:0] y,
    input  logic            op_add,
    output logic [KF_W-1:0] z
);

    tc_t xt;
    tc_t yt;
    tc_t st;

    // W+1 bits hold any sum of two in-range magnitudes, so no overflow before clamping.
    always_comb begin
        xt = sm_to_tc(x);
        yt = sm_to_tc(y);
        if (op_add) begin
            st = xt + yt;
        end else begin
            st = xt - yt;
        end
        z = tc_to_sm_sat(st);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one saturating adder/subtractor, with a registered response stage.
// Optional stall counter (busy_cnt) enabled by defining ADDSUB_ARB_PERF_EN.
module addsub_arbiter
    import kf_arith_pkg::*;
#(
    parameter int W    = KF_W,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    input  logic [NREQ-1:0]     req_op_add,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data
`ifdef ADDSUB_ARB_PERF_EN
    ,
    output logic [15:0]         busy_cnt
`endif
);

    rsp_state_e     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;

    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic           can_issue;
    logic           xfer;
    logic [W-1:0]   x_sel;
    logic [W-1:0]   y_sel;
    logic           add_sel;
    logic [W-1:0]   sum;

    // Round-robin search: walk downward so the smallest offset from rr_q is the last writer.
    always_comb begin
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = {IDW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(rr_q) + k) % NREQ;
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end else begin
                grant_vld = grant_vld;
                grant_idx = grant_idx;
            end
        end
    end

    // Operand mux onto the shared datapath.
    always_comb begin
        int gi;
        gi      = int'(grant_idx);
        x_sel   = req_x[gi*W +: W];
        y_sel   = req_y[gi*W +: W];
        add_sel = req_op_add[gi];
    end

    adder_subs u_adder_subs (
        .x      (x_sel),
        .y      (y_sel),
        .op_add (add_sel),
        .z      (sum)
    );

    // Issue decision, grant outputs and response-stage next state.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        can_issue  = (state_q == RSP_EMPTY) || rsp_ready;
        xfer       = can_issue && grant_vld && !rst;
        if (xfer) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        case (state_q)
            RSP_EMPTY: begin
                if (xfer) begin
                    state_d = RSP_FULL;
                end else begin
                    state_d = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                if (xfer) begin
                    state_d = RSP_FULL;
                end else if (rsp_ready) begin
                    state_d = RSP_EMPTY;
                end else begin
                    state_d = RSP_FULL;
                end
            end
            default: begin
                state_d = RSP_EMPTY;
            end
        endcase
        if (xfer) begin
            rsp_id_d   = grant_idx;
            rsp_data_d = sum;
            if (grant_idx == IDW'(NREQ - 1)) begin
                rr_d = {IDW{1'b0}};
            end else begin
                rr_d = grant_idx + IDW'(1'b1);
            end
        end else begin
            rsp_id_d   = rsp_id_q;
            rsp_data_d = rsp_data_q;
            rr_d       = rr_q;
        end
    end

    // Response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RSP_EMPTY;
            rr_q       <= {IDW{1'b0}};
            rsp_id_q   <= {IDW{1'b0}};
            rsp_data_q <= {W{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == RSP_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ADDSUB_ARB_PERF_EN
    logic [15:0] busy_q, busy_d;
    logic        stall;

    // Counts cycles with at least one valid request left unserved; saturates.
    always_comb begin
        stall = |(req_valid & ~req_ready);
        if (stall && (busy_q != 16'hFFFF)) begin
            busy_d = busy_q + 16'd1;
        end else begin
            busy_d = busy_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 16'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_cnt = busy_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (define ADDSUB_ARB_PERF_EN to cover busy_cnt).
module tb_addsub_arbiter;

    localparam int W    = 24;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [23:0] AX [0:7] = '{24'h000005, 24'h000003, 24'h7FFFFF, 24'hFFFFFF,
                                          24'h800000, 24'h000004, 24'h800005, 24'h800005};
    localparam logic [23:0] AY [0:7] = '{24'h800003, 24'h000005, 24'h000001, 24'h000001,
                                          24'h000000, 24'h000004, 24'h800003, 24'h000002};
    localparam logic        AA [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [23:0] AE [0:7] = '{24'h000002, 24'h800002, 24'h7FFFFF, 24'hFFFFFF,
                                          24'h000000, 24'h000000, 24'h800002, 24'h800003};

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_x;
    logic [NREQ*W-1:0]   req_y;
    logic [NREQ-1:0]     req_op_add;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data;
`ifdef ADDSUB_ARB_PERF_EN
    logic [15:0]         busy_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op_add (req_op_add),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ADDSUB_ARB_PERF_EN
        ,
        .busy_cnt   (busy_cnt)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [23:0] x, input logic [23:0] y, input logic add);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_op_add[i]   = add;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000);
        end
        rst       = 1'b0;
        req_valid = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 24'h000000) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b id=%0d data=%h expected 0/0/000000",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(1, 24'h000005, 24'h800003, 1'b1);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0010);
        end
        cycle();
        req_valid = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 24'h000002) begin
            failures++;
            $display("FAIL single_rsp: got valid=%b id=%0d data=%h expected 1/1/000002",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_arith();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(2, AX[i], AY[i], AA[i]);
            req_valid = 4'b0100;
            cycle();
            req_valid = 4'b0000;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== AE[i]) begin
                failures++;
                $display("FAIL arith_%0d: got valid=%b id=%0d data=%h expected 1/2/%h",
                         i, rsp_valid, rsp_id, rsp_data, AE[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [23:0] exp_d;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 24'(i + 1), 24'h000001, 1'b1);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL fair_first_grant: got %b expected %b", req_ready, 4'b0001);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            exp_d = 24'((k % 4) + 2);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== exp_d) begin
                failures++;
                $display("FAIL fair_%0d: got valid=%b id=%0d data=%h expected 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_data, k % 4, exp_d);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 24'h00000A, 24'h000003, 1'b0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_first_grant: got %b expected %b", req_ready, 4'b0001);
        end
        cycle();
        set_req(3, 24'h800001, 24'h000001, 1'b0);
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
                rsp_data !== 24'h000007) begin
                failures++;
                $display("FAIL bp_hold_%0d: got ready=%b valid=%b id=%0d data=%h expected 0000/1/0/000007",
                         k, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_release_grant: got %b expected %b", req_ready, 4'b1000);
        end
        cycle();
        req_valid = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 24'h800002) begin
            failures++;
            $display("FAIL bp_release_rsp: got valid=%b id=%0d data=%h expected 1/3/800002",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rsp_ready = 1'b0;
        set_req(2, 24'h000001, 24'h000001, 1'b1);
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0000;
        rst       = 1'b1;
        cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_valid: got %b expected 0", rsp_valid);
        end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_ghost_%0d: got valid=%b expected 0", k, rsp_valid);
            end
        end
        set_req(0, 24'h000001, 24'h000006, 1'b1);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_ptr: got %b expected %b", req_ready, 4'b0001);
        end
        cycle();
        req_valid = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'h000007) begin
            failures++;
            $display("FAIL midrst_rsp: got valid=%b id=%0d data=%h expected 1/0/000007",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

`ifdef ADDSUB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (busy_cnt !== 16'd0) begin
            failures++;
            $display("FAIL perf_reset: got %0d expected 0", busy_cnt);
        end
        rsp_ready = 1'b0;
        set_req(0, 24'h000001, 24'h000001, 1'b1);
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0100;
        repeat (5) cycle();
        req_valid = 4'b0000;
        checks++;
        if (busy_cnt !== 16'd5) begin
            failures++;
            $display("FAIL perf_count: got %0d expected 5", busy_cnt);
        end
        req_valid = 4'b0100;
        repeat (65535) cycle();
        checks++;
        if (busy_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL perf_sat: got %h expected ffff", busy_cnt);
        end
        cycle();
        req_valid = 4'b0000;
        checks++;
        if (busy_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL perf_sat_hold: got %h expected ffff", busy_cnt);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_x      = {(NREQ*W){1'b0}};
        req_y      = {(NREQ*W){1'b0}};
        req_op_add = 4'b0000;
        rsp_ready  = 1'b1;
        test_reset();
        test_single();
        test_arith();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
`ifdef ADDSUB_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one sign-magnitude saturating adder/subtractor among NREQ requesters in the Kalman-filter datapath (state-predict, covariance-update and innovation units). Accepts at most one operation per cycle, computes X ± Y with saturation to the sign-magnitude range, and returns the result tagged with the requester index through a single-entry registered response stage with valid/ready backpressure.

## Interface
- W, 24, operand/result width, sign-magnitude (MSB sign, W-1 magnitude bits)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester index width; must satisfy 2^IDW >= NREQ
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_x  in  NREQ*W  X operands, requester i at [i*W +: W]
- req_y  in  NREQ*W  Y operands, same packing
- req_op_add  in  NREQ  1 = X+Y, 0 = X−Y, per requester
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of requester that issued the result
- rsp_data  out  W  saturated sign-magnitude result
- busy_cnt  out  16  (only with ADDSUB_ARB_PERF_EN) stalled-request counter

## Operation
- Decided: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- Response stage states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_issue = EMPTY or (FULL and rsp_ready).
- Grant: when can_issue, the lowest index i >= rr_ptr (wrapping modulo NREQ) with req_valid[i]=1 gets req_ready[i]=1; all other req_ready=0. When not can_issue, req_ready = 0.
- Transfer on requester i = req_valid[i] & req_ready[i]. On transfer: rsp_data <= sat(X_i ± Y_i), rsp_id <= i, state FULL, rr_ptr <= (i+1) mod NREQ.
- FULL & rsp_ready & no transfer → EMPTY. FULL & rsp_ready & transfer → stays FULL with new result (back-to-back, full throughput).
- rr_ptr unchanged when no transfer.
- Arithmetic: convert each operand to W+1-bit two's complement (sign ? −mag : mag), add or subtract, take |Z|, clamp to 2^(W−1)−1, sign = (Z<0). Negative zero inputs (0x800000 for W=24) are treated as zero; a zero result is always +0.
- req_ready is combinational from req_valid, rr_ptr, state and rsp_ready; requesters must not make req_valid depend on req_ready.
- rsp_data/rsp_id held stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0, busy_cnt=0; req_ready=0 during the rst cycle.
- Latency: transfer in cycle n → rsp_valid=1 with result in cycle n+1.
- Throughput: one operation per cycle when rsp_ready held high.
- Reset mid-operation: pending response is discarded; no response ever appears for it.
- Requester whose req_valid drops before being granted loses nothing; no state kept per requester.

## Configuration
- ADDSUB_ARB_PERF_EN defined: busy_cnt port present; increments by 1 each cycle in which any req_valid[i]=1 is not transferred (counts cycles, not requesters), saturates at 0xFFFF, cleared by rst.
- Undefined: busy_cnt port and counter absent; all other behaviour identical.

## Structure
- Shared package `kf_arith_pkg`: W default, MAG_MAX constant, sm→tc and tc→sm-saturate functions.
- Sub-module `adder_subs` (existing sign-magnitude saturating adder) instantiated once on the muxed granted operands; arbiter contains grant logic, rr_ptr, response register, optional counter.

## Test plan
- Single request: req 1 with X=0x000005, Y=0x800003, op_add=1 → next cycle rsp_valid=1, rsp_id=1, rsp_data=0x000002.
- Subtract/saturate: X=0x000003−Y=0x000005 → 0x800002; X=0x7FFFFF+Y=0x000001 → 0x7FFFFF; X=0xFFFFFF−0x000001 → 0xFFFFFF; X=0x800000+0x000000 → 0x000000.
- Fairness: all four req_valid held high, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,… one per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with a response FULL → req_ready all 0, rsp_data/rsp_id stable; rsp_ready=1 → next grant same cycle, new result following cycle.
- Reset mid-flight: assert rst in the cycle after a transfer → rsp_valid=0 next cycle, rr_ptr restarts at 0 (req 0 granted first).
- PERF_EN: req 2 valid while rsp_ready=0 and FULL for 5 cycles → busy_cnt=5; counter stops at 0xFFFF after long stall.
